// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss.cc stopwatch: FSM encoding, BCD digit limits,
// the packed digit bundle and the prescaler width helper.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int unsigned ONES_MAX = 9;
    localparam int unsigned TENS_MAX = 5;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] cs_t;
        logic [3:0] cs_o;
    } bcd_time_t;

    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses and display/status outputs of the stopwatch core.
// master drives the pulses and observes the display; slave is the core.
interface stopwatch_if;

    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output start_stop, clear, lap,
        input  min_t, min_o, sec_t, sec_o, cs_t, cs_o, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, clear, lap,
        output min_t, min_o, sec_t, sec_o, cs_t, cs_o, running, lap_active, wrap
    );

endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; carry is combinational so a whole chain of
// digits settles within the single tick edge.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = ONES_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    localparam logic [3:0] DMAX = 4'(MAX);

    logic [3:0] r_digit;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_digit <= '0;
        end else if (en) begin
            r_digit <= (r_digit == DMAX) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign digit = r_digit;
    assign carry = en && (r_digit == DMAX);

endmodule

// File: rtl/stopwatch_core.sv
// mm:ss.cc stopwatch: IDLE/RUN/PAUSE control, centisecond prescaler, six chained
// BCD digits. Define STOPWATCH_LAP_HOLD_EN to build the lap snapshot/freeze feature.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    stopwatch_if.slave bus
);

    localparam int unsigned   DIV        = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW         = presc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          r_wrap;
    logic          w_run;
    logic          w_tick;
    logic          w_clear_cnt;

    logic w_en_cs_o, w_en_cs_t, w_en_sec_o, w_en_sec_t, w_en_min_o, w_en_min_t;
    logic w_cy_cs_o, w_cy_cs_t, w_cy_sec_o, w_cy_sec_t, w_cy_min_o, w_cy_min_t;
    logic [3:0] w_cs_o, w_cs_t, w_sec_o, w_sec_t, w_min_o, w_min_t;

    bcd_time_t w_live;
    bcd_time_t w_disp;
    logic      w_lap_active;

    assign w_run       = (r_state == ST_RUN);
    assign w_tick      = w_run && (r_presc == PRESC_LAST);
    // clear is only honoured while stopped; in RUN it has no effect at all
    assign w_clear_cnt = bus.clear && !w_run;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.start_stop) w_state_nxt = ST_PAUSE;
            end
            ST_IDLE, ST_PAUSE: begin
                if (bus.clear)           w_state_nxt = ST_IDLE;
                else if (bus.start_stop) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wrap  <= w_cy_min_t;
            if (w_clear_cnt) begin
                r_presc <= '0;
            end else if (w_run) begin
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            end
        end
    end

    assign w_en_cs_o  = w_tick;
    assign w_en_cs_t  = w_cy_cs_o;
    assign w_en_sec_o = w_cy_cs_t;
    assign w_en_sec_t = w_cy_sec_o;
    assign w_en_min_o = w_cy_sec_t;
    assign w_en_min_t = w_cy_min_o;

    bcd_digit_cnt #(.MAX(ONES_MAX)) u_cs_o (
        .clk(clk), .rst_n(rst_n), .en(w_en_cs_o), .clr(w_clear_cnt),
        .digit(w_cs_o), .carry(w_cy_cs_o)
    );
    bcd_digit_cnt #(.MAX(ONES_MAX)) u_cs_t (
        .clk(clk), .rst_n(rst_n), .en(w_en_cs_t), .clr(w_clear_cnt),
        .digit(w_cs_t), .carry(w_cy_cs_t)
    );
    bcd_digit_cnt #(.MAX(ONES_MAX)) u_sec_o (
        .clk(clk), .rst_n(rst_n), .en(w_en_sec_o), .clr(w_clear_cnt),
        .digit(w_sec_o), .carry(w_cy_sec_o)
    );
    bcd_digit_cnt #(.MAX(TENS_MAX)) u_sec_t (
        .clk(clk), .rst_n(rst_n), .en(w_en_sec_t), .clr(w_clear_cnt),
        .digit(w_sec_t), .carry(w_cy_sec_t)
    );
    bcd_digit_cnt #(.MAX(ONES_MAX)) u_min_o (
        .clk(clk), .rst_n(rst_n), .en(w_en_min_o), .clr(w_clear_cnt),
        .digit(w_min_o), .carry(w_cy_min_o)
    );
    bcd_digit_cnt #(.MAX(TENS_MAX)) u_min_t (
        .clk(clk), .rst_n(rst_n), .en(w_en_min_t), .clr(w_clear_cnt),
        .digit(w_min_t), .carry(w_cy_min_t)
    );

    assign w_live = '{min_t: w_min_t, min_o: w_min_o, sec_t: w_sec_t,
                      sec_o: w_sec_o, cs_t: w_cs_t, cs_o: w_cs_o};

`ifdef STOPWATCH_LAP_HOLD_EN
    bcd_time_t r_snap;
    logic      r_lap_active;

    // snapshot samples the registered digits, i.e. the value before a coincident tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lap_active <= 1'b0;
        end else if (w_clear_cnt) begin
            r_lap_active <= 1'b0;
        end else if (bus.lap) begin
            r_lap_active <= w_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !w_clear_cnt && bus.lap && w_run) begin
            r_snap <= w_live;
        end
    end

    assign w_lap_active = r_lap_active;
    assign w_disp       = r_lap_active ? r_snap : w_live;
`else
    logic w_unused_lap;

    assign w_unused_lap = bus.lap;
    assign w_lap_active = 1'b0;
    assign w_disp       = w_live;
`endif

    assign bus.min_t      = w_disp.min_t;
    assign bus.min_o      = w_disp.min_o;
    assign bus.sec_t      = w_disp.sec_t;
    assign bus.sec_o      = w_disp.sec_o;
    assign bus.cs_t       = w_disp.cs_t;
    assign bus.cs_o       = w_disp.cs_o;
    assign bus.running    = w_run;
    assign bus.lap_active = w_lap_active;
    assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core (DIV=10): a centisecond-count reference model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_stopwatch_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int FULL    = 60 * 60 * 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stopwatch_if bus ();

    stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tgt;
        logic [26:0] exp;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // reference model: whole count in centiseconds, phase of the prescaler
    int m_state = 0;   // 0 idle, 1 running, 2 paused
    int m_cnt   = 0;
    int m_pre   = 0;
    int m_snap  = 0;
    bit m_lap   = 0;
    bit m_wrap  = 0;

    function automatic logic [26:0] expect_vec();
        int disp, mins, secs, cs;
        disp = m_lap ? m_snap : m_cnt;
        mins = disp / 6000;
        secs = (disp / 100) % 60;
        cs   = disp % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(cs / 10), 4'(cs % 10), (m_state == 1), m_lap, m_wrap};
    endfunction

    task automatic model_step(input bit rs, input bit ss, input bit cl, input bit lp);
        bit tick, eff_clr;
        if (!rs) begin
            m_state = 0; m_cnt = 0; m_pre = 0; m_lap = 0; m_wrap = 0;
            return;
        end
        tick    = (m_state == 1) && (m_pre == DIV - 1);
        eff_clr = cl && (m_state != 1);
        m_wrap  = tick && (m_cnt == FULL - 1);
`ifdef STOPWATCH_LAP_HOLD_EN
        if (eff_clr) m_lap = 0;
        else if (lp) begin
            if (m_state == 1) begin
                m_snap = m_cnt;
                m_lap  = 1;
            end else begin
                m_lap = 0;
            end
        end
`else
        if (lp) m_lap = 0;
`endif
        if (eff_clr) begin
            m_cnt = 0;
            m_pre = 0;
        end else begin
            if (tick) m_cnt = (m_cnt + 1) % FULL;
            if (m_state == 1) m_pre = (m_pre + 1) % DIV;
        end
        if (m_state == 1) begin
            if (ss) m_state = 2;
        end else if (cl) begin
            m_state = 0;
        end else if (ss) begin
            m_state = 1;
        end
    endtask

    task automatic cyc(input bit rs, input bit ss, input bit cl, input bit lp, input string tag);
        exp_t e;
        rst_n          = rs;
        bus.start_stop = ss;
        bus.clear      = cl;
        bus.lap        = lp;
        model_step(rs, ss, cl, lp);
        e.tgt = cyc_n + 1;
        e.exp = expect_vec();
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.lap        = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    always @(negedge clk) begin
        logic [26:0] got;
        exp_t        e;
        if (sbq.size() > 0 && sbq[0].tgt == cyc_n) begin
            e   = sbq.pop_front();
            got = {bus.min_t, bus.min_o, bus.sec_t, bus.sec_o, bus.cs_t, bus.cs_o,
                   bus.running, bus.lap_active, bus.wrap};
            checks++;
            if (got !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got mm:ss.cc=%h%h:%h%h.%h%h run=%b lap=%b wrap=%b required mm:ss.cc=%h%h:%h%h.%h%h run=%b lap=%b wrap=%b",
                         e.tag, cyc_n, got[26:23], got[22:19], got[18:15], got[14:11],
                         got[10:7], got[6:3], got[2], got[1], got[0],
                         e.exp[26:23], e.exp[22:19], e.exp[18:15], e.exp[14:11],
                         e.exp[10:7], e.exp[6:3], e.exp[2], e.exp[1], e.exp[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.lap        = 1'b0;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, "reset_ignores_inputs");

        // first increment exactly DIV cycles after start, then 100 ticks total
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "start");
        idle(DIV, "first_tick");
        idle(99 * DIV, "run_100_ticks");
        idle(3, "run_phase");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "pause");
        idle(50, "pause_hold");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume");
        idle(2 * DIV, "resume_phase");

        cyc(1'b1, 1'b0, 1'b1, 1'b0, "clear_in_run");
        idle(5, "after_clear_in_run");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "pause2");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "ss_clear_in_pause");
        idle(3, "idle_after_clear");

        // lap at 00:01.23, update, then release from pause
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "start_lap_run");
        idle(123 * DIV, "to_1_23");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "lap_capture");
        idle(40, "lap_hold");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "lap_update");
        idle(20, "lap_hold2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "pause_lap");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "lap_in_pause");
        idle(5, "live_after_lap_pause");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume_lap");
        idle(15, "run_before_lap");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "lap_again");
        idle(7, "lap_hold3");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, "reset_mid_run");
        idle(5, "idle_after_reset");

        // preload 59:59.99 while paused by driving each digit enable directly
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "start_for_wrap");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "pause_for_wrap");
        force dut.w_en_min_t = 1'b1;  repeat (5) @(posedge clk); #1; release dut.w_en_min_t;
        force dut.w_en_min_o = 1'b1;  repeat (9) @(posedge clk); #1; release dut.w_en_min_o;
        force dut.w_en_sec_t = 1'b1;  repeat (5) @(posedge clk); #1; release dut.w_en_sec_t;
        force dut.w_en_sec_o = 1'b1;  repeat (9) @(posedge clk); #1; release dut.w_en_sec_o;
        force dut.w_en_cs_t  = 1'b1;  repeat (9) @(posedge clk); #1; release dut.w_en_cs_t;
        force dut.w_en_cs_o  = 1'b1;  repeat (9) @(posedge clk); #1; release dut.w_en_cs_o;
        m_cnt = FULL - 1;
        idle(3, "preloaded_59_59_99");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume_wrap");
        idle(2 * DIV, "wrap");

        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 599) != 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 24) == 0), "random");
        end

        idle(2, "drain");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
